// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM encoding,
// requester identifiers and the word-alignment helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic OWNER_CPU  = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam int         CNT_W           = 4;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; remembers which requester was served last.
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_served_r;

  // Grant selection: contention goes to whoever was not served last
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_served_r == OWNER_HOST) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Last-served register; host after reset so the CPU wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served_r <= OWNER_HOST;
    end else if (update) begin
      last_served_r <= (grant == 2'b10) ? OWNER_HOST : OWNER_CPU;
    end else begin
      last_served_r <= last_served_r;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares one fixed-latency single-port data memory between the CPU load/store
// path and the host/loader port; one access at a time, one-cycle ack.
module dm_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  output logic          c_err,
  output logic          c_stall,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata,
  output logic          h_err,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             owner_r, owner_s;
  logic             m_en_r, m_en_s, m_we_r, m_we_s;
  logic [AW-1:0]    m_addr_r, m_addr_s;
  logic [DW-1:0]    m_wdata_r, m_wdata_s;
  logic             c_ack_r, h_ack_r, c_err_r, h_err_r;
  logic [DW-1:0]    c_rdata_r, h_rdata_r;
  logic [1:0]       grant_s;
  logic             host_win_s, grant_upd_s, resp_s, err_s;
  logic             win_we_s;
  logic [AW-1:0]    win_addr_s;
  logic [DW-1:0]    win_wdata_s;
  logic [DW-1:0]    rdata_s;

  rr_arb2 u_arb (
    .clk    (CLK),
    .rst_n  (RST),
    .req    ({h_req, c_req}),
    .update (grant_upd_s),
    .grant  (grant_s)
  );

  assign host_win_s  = (grant_s == 2'b10);
  assign win_we_s    = host_win_s ? h_we    : c_we;
  assign win_addr_s  = host_win_s ? h_addr  : c_addr;
  assign win_wdata_s = host_win_s ? h_wdata : c_wdata;

  // Next-state and next-output logic of the access sequencer
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    owner_s     = owner_r;
    m_en_s      = 1'b0;
    m_we_s      = m_we_r;
    m_addr_s    = m_addr_r;
    m_wdata_s   = m_wdata_r;
    grant_upd_s = 1'b0;
    resp_s      = 1'b0;
    err_s       = 1'b0;
    rdata_s     = '0;
    case (state_r)
      ST_IDLE: begin
        if (c_req || h_req) begin
          grant_upd_s = 1'b1;
          owner_s     = host_win_s ? OWNER_HOST : OWNER_CPU;
          if (is_misaligned(win_addr_s[1:0])) begin
            // Rejected without touching memory; m_* keep their last values
            state_s = ST_RESP;
            resp_s  = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s   = ST_ISSUE;
            m_en_s    = 1'b1;
            m_we_s    = win_we_s;
            m_addr_s  = win_addr_s;
            m_wdata_s = win_wdata_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_s   = CNT_W'(LAT - 1);
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_RESP;
          resp_s  = 1'b1;
          rdata_s = m_we_r ? {DW{1'b0}} : m_rdata;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, memory-side and requester-side output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      owner_r   <= OWNER_CPU;
      m_en_r    <= 1'b0;
      m_we_r    <= 1'b0;
      m_addr_r  <= '0;
      m_wdata_r <= '0;
      c_ack_r   <= 1'b0;
      h_ack_r   <= 1'b0;
      c_err_r   <= 1'b0;
      h_err_r   <= 1'b0;
      c_rdata_r <= '0;
      h_rdata_r <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      owner_r   <= owner_s;
      m_en_r    <= m_en_s;
      m_we_r    <= m_we_s;
      m_addr_r  <= m_addr_s;
      m_wdata_r <= m_wdata_s;
      c_ack_r   <= resp_s && (owner_s == OWNER_CPU);
      h_ack_r   <= resp_s && (owner_s == OWNER_HOST);
      c_err_r   <= err_s && (owner_s == OWNER_CPU);
      h_err_r   <= err_s && (owner_s == OWNER_HOST);
      c_rdata_r <= (resp_s && (owner_s == OWNER_CPU))  ? rdata_s : {DW{1'b0}};
      h_rdata_r <= (resp_s && (owner_s == OWNER_HOST)) ? rdata_s : {DW{1'b0}};
    end
  end

  assign c_ack   = c_ack_r;
  assign c_rdata = c_rdata_r;
  assign c_err   = c_err_r;
  assign c_stall = c_req & ~c_ack_r;
  assign h_ack   = h_ack_r;
  assign h_rdata = h_rdata_r;
  assign h_err   = h_err_r;
  assign m_en    = m_en_r;
  assign m_we    = m_we_r;
  assign m_addr  = m_addr_r;
  assign m_wdata = m_wdata_r;
  assign busy    = (state_r != ST_IDLE);
  assign owner   = owner_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a LAT=1 and a LAT=3 instance, each with its own memory
// model; the instance not under test is held in reset.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic rst1, rst3;
  logic c_req, c_we, h_req, h_we;
  logic [31:0] c_addr, c_wdata, h_addr, h_wdata;

  logic c_ack1, c_err1, c_stall1, h_ack1, h_err1, m_en1, m_we1, busy1, owner1;
  logic [31:0] c_rdata1, h_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic c_ack3, c_err3, c_stall3, h_ack3, h_err3, m_en3, m_we3, busy3, owner3;
  logic [31:0] c_rdata3, h_rdata3, m_addr3, m_wdata3, m_rdata3;

  always #5 clk = ~clk;

  dm_arbiter #(.DW(32), .AW(32), .LAT(1)) u_dut1 (
    .CLK(clk), .RST(rst1),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack1), .c_rdata(c_rdata1), .c_err(c_err1), .c_stall(c_stall1),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack1), .h_rdata(h_rdata1), .h_err(h_err1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_rdata(m_rdata1), .busy(busy1), .owner(owner1)
  );

  dm_arbiter #(.DW(32), .AW(32), .LAT(3)) u_dut3 (
    .CLK(clk), .RST(rst3),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack3), .c_rdata(c_rdata3), .c_err(c_err3), .c_stall(c_stall3),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack3), .h_rdata(h_rdata3), .h_err(h_err3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3),
    .m_rdata(m_rdata3), .busy(busy3), .owner(owner3)
  );

  // Memory models: read data is garbage except in the LAT-th cycle after m_en
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] rd1;
  logic [31:0] p3 [0:2];
  always @(posedge clk) begin
    if (m_en1 && m_we1) mem1[m_addr1[7:2]] <= m_wdata1;
    rd1 <= (m_en1 && !m_we1) ? mem1[m_addr1[7:2]] : 32'hA5A5_A5A5;
    if (m_en3 && m_we3) mem3[m_addr3[7:2]] <= m_wdata3;
    p3[0] <= (m_en3 && !m_we3) ? mem3[m_addr3[7:2]] : 32'hA5A5_A5A5;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign m_rdata1 = rd1;
  assign m_rdata3 = p3[2];

  int cur = 0;
  int n_checks = 0;
  int n_fail = 0;
  int men_cnt = 0;
  logic [31:0] last_maddr, last_mwdata;
  logic last_mwe;

  logic s_c_ack, s_h_ack, s_c_err, s_h_err, s_c_stall, s_busy, s_owner, s_m_en, s_m_we;
  logic [31:0] s_c_rdata, s_h_rdata, s_m_addr, s_m_wdata;
  assign s_c_ack   = (cur == 1) ? c_ack3   : c_ack1;
  assign s_h_ack   = (cur == 1) ? h_ack3   : h_ack1;
  assign s_c_err   = (cur == 1) ? c_err3   : c_err1;
  assign s_h_err   = (cur == 1) ? h_err3   : h_err1;
  assign s_c_stall = (cur == 1) ? c_stall3 : c_stall1;
  assign s_busy    = (cur == 1) ? busy3    : busy1;
  assign s_owner   = (cur == 1) ? owner3   : owner1;
  assign s_m_en    = (cur == 1) ? m_en3    : m_en1;
  assign s_m_we    = (cur == 1) ? m_we3    : m_we1;
  assign s_c_rdata = (cur == 1) ? c_rdata3 : c_rdata1;
  assign s_h_rdata = (cur == 1) ? h_rdata3 : h_rdata1;
  assign s_m_addr  = (cur == 1) ? m_addr3  : m_addr1;
  assign s_m_wdata = (cur == 1) ? m_wdata3 : m_wdata1;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl [0:6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit port, input logic [31:0] rdata, input bit err);
    exp_t e;
    e.port = port; e.rdata = rdata; e.err = err;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input bit port, input logic [31:0] rdata, input bit err);
    exp_t e;
    if (sbq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected ack: port %0d rdata 0x%h, expected no ack", port, rdata);
    end else begin
      e = sbq.pop_front();
      chk("sb port", {31'd0, port}, {31'd0, e.port});
      chk("sb rdata", rdata, e.rdata);
      chk("sb err", {31'd0, err}, {31'd0, e.err});
    end
  endtask

  // Output monitor: m_en bookkeeping and scoreboard comparison on every ack
  initial begin
    forever begin
      @(negedge clk);
      if (s_m_en) begin
        men_cnt++;
        last_maddr  = s_m_addr;
        last_mwe    = s_m_we;
        last_mwdata = s_m_wdata;
      end
      if (s_c_ack) sb_pop(1'b0, s_c_rdata, s_c_err);
      if (s_h_ack) sb_pop(1'b1, s_h_rdata, s_h_err);
    end
  end

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      h_req = req; h_we = we; h_addr = addr; h_wdata = wdata;
    end else begin
      c_req = req; c_we = we; c_addr = addr; c_wdata = wdata;
    end
  endtask

  task automatic wait_ack(input bit port, input int exp_edges, input string name);
    int edges = 0;
    bit seen = 1'b0;
    while (!seen && edges < 40) begin
      @(negedge clk); #1;
      edges++;
      if (port ? s_h_ack : s_c_ack) seen = 1'b1;
      else if (!port) chk({name, " stall"}, {31'd0, s_c_stall}, 32'd1);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s ack: got none in 40 cycles, expected ack", name);
    end else begin
      chk({name, " latency"}, edges, exp_edges);
      chk({name, " owner"}, {31'd0, s_owner}, {31'd0, port});
      if (!port) chk({name, " stall at ack"}, {31'd0, s_c_stall}, 32'd0);
    end
    if (port) h_req = 1'b0; else c_req = 1'b0;
  endtask

  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input string name);
    bit err;
    int m0;
    int lat;
    lat = (cur == 1) ? 3 : 1;
    err = (addr[1:0] != 2'b00);
    @(negedge clk); #1;
    m0 = men_cnt;
    drive(port, 1'b1, we, addr, wdata);
    #1;
    if (!port) chk({name, " stall on req"}, {31'd0, s_c_stall}, 32'd1);
    push_exp(port, (err || we) ? 32'd0 : exp_rdata, err);
    wait_ack(port, err ? 1 : lat + 2, name);
    chk({name, " m_en count"}, men_cnt - m0, err ? 32'd0 : 32'd1);
    if (!err) begin
      chk({name, " m_addr"}, last_maddr, addr);
      chk({name, " m_we"}, {31'd0, last_mwe}, {31'd0, we});
      if (we) chk({name, " m_wdata"}, last_mwdata, wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int m0;
    bit seen;
    rst1 = 1'b0; rst3 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    tbl[0] = '{1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h24, 32'h0BAD_F00D, 32'h0};
    tbl[3] = '{1'b0, 32'h24, 32'h0,         32'h0BAD_F00D};
    tbl[4] = '{1'b0, 32'h22, 32'h0,         32'h0};
    tbl[5] = '{1'b1, 32'h23, 32'hFFFF_FFFF, 32'h0};
    tbl[6] = '{1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF};

    // Reset state of both instances
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cur = i;
      #1;
      chk("reset busy", {31'd0, s_busy}, 32'd0);
      chk("reset owner", {31'd0, s_owner}, 32'd0);
      chk("reset m_en", {31'd0, s_m_en}, 32'd0);
      chk("reset c_ack", {31'd0, s_c_ack}, 32'd0);
      chk("reset h_ack", {31'd0, s_h_ack}, 32'd0);
      chk("reset c_rdata", s_c_rdata, 32'd0);
      chk("reset m_addr", s_m_addr, 32'd0);
    end

    // Table-driven CPU accesses on the LAT=1 instance
    cur = 0;
    @(negedge clk); rst1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      access(1'b0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, $sformatf("vec%0d", i));
    end

    // Contention from reset release: strict alternation, CPU first
    @(negedge clk); #1;
    rst1 = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h24, 32'd0);
    for (int g = 0; g < 4; g++) push_exp(g[0], (g[0] ? 32'h0BAD_F00D : 32'hDEAD_BEEF), 1'b0);
    @(negedge clk); #1;
    rst1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      edges = 0;
      seen = 1'b0;
      while (!seen && edges < 20) begin
        @(negedge clk); #1;
        edges++;
        if (s_c_ack || s_h_ack) seen = 1'b1;
      end
      if (!seen) begin
        n_checks++;
        n_fail++;
        $display("FAIL contention grant %0d: got no ack, expected ack", g);
      end else begin
        chk($sformatf("contention owner %0d", g), {31'd0, s_owner}, {31'd0, g[0]});
        chk($sformatf("contention spacing %0d", g), edges, (g == 0) ? 32'd3 : 32'd4);
      end
      if (g == 3) begin
        c_req = 1'b0;
        h_req = 1'b0;
      end
    end
    repeat (8) @(negedge clk);
    #1;
    chk("contention leftover", sbq.size(), 32'd0);

    // LAT=3: host write then host read of 0x40
    rst1 = 1'b0;
    cur = 1;
    @(negedge clk); rst3 = 1'b1;
    access(1'b1, 1'b1, 32'h40, 32'h1234_5678, 32'h0, "host wr");
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1234_5678, "host rd");

    // Reset asserted two cycles after m_en, while waiting on memory
    @(negedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk); #1;
      if (s_m_en) seen = 1'b1;
    end
    chk("rst m_en seen", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk);
    #1;
    rst3 = 1'b0;
    #1;
    chk("rst busy", {31'd0, s_busy}, 32'd0);
    chk("rst c_ack", {31'd0, s_c_ack}, 32'd0);
    chk("rst m_en", {31'd0, s_m_en}, 32'd0);
    chk("rst stall", {31'd0, s_c_stall}, 32'd1);
    @(negedge clk); #1;
    m0 = men_cnt;
    rst3 = 1'b1;
    push_exp(1'b0, 32'h1234_5678, 1'b0);
    wait_ack(1'b0, 5, "regrant");
    chk("regrant m_en count", men_cnt - m0, 32'd1);

    // CPU drops its request during WAIT: the ack still pulses once
    @(negedge clk); #1;
    m0 = men_cnt;
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
    push_exp(1'b0, 32'h1234_5678, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk); #1;
      if (s_m_en) seen = 1'b1;
    end
    @(negedge clk); #1;
    c_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk); #1;
      if (s_c_ack) seen = 1'b1;
    end
    chk("drop ack seen", {31'd0, seen}, 32'd1);
    repeat (8) @(negedge clk);
    #1;
    chk("drop m_en count", men_cnt - m0, 32'd1);
    chk("drop leftover", sbq.size(), 32'd0);
    chk("drop idle", {31'd0, s_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
